// File: rtl/mips_defs_pkg.sv
// Shared IF-stage definitions: default vectors, next-PC select encoding, PC helpers.
// Optional build macro used by pc_fetch_unit: FETCH_PERF_CNT_EN.
package mips_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;

  typedef enum logic [2:0] {
    PCSEL_SEQ,
    PCSEL_BR,
    PCSEL_J,
    PCSEL_JR,
    PCSEL_ERET,
    PCSEL_IRQ,
    PCSEL_EXC,
    PCSEL_HOLD
  } pcsel_e;

  // The supervisor bit rides in pc[31]; sequential fetch never changes privilege.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/npc_select.sv
// Combinational next-PC priority mux for the IF stage; no state.
module npc_select
  import mips_defs::*;
#(
  parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic [31:0] pc,
  input  logic [30:0] epc_low,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [30:0] jump_target_low,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        eret,
  input  logic        exc_req,
  input  logic        irq_accept,
  output logic [31:0] next_pc,
  output pcsel_e      sel,
  output logic        flush
);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel = PCSEL_SEQ;
    if      (exc_req)      sel = PCSEL_EXC;
    else if (irq_accept)   sel = PCSEL_IRQ;
    else if (stall)        sel = PCSEL_HOLD;
    else if (eret)         sel = PCSEL_ERET;
    else if (jr)           sel = PCSEL_JR;
    else if (branch_taken) sel = PCSEL_BR;
    else if (jump)         sel = PCSEL_J;
  end

  always_comb begin
    next_pc = pc_plus4(pc);
    unique case (sel)
      PCSEL_EXC:  next_pc = EXC_VEC;
      PCSEL_IRQ:  next_pc = IRQ_VEC;
      PCSEL_HOLD: next_pc = pc;
      PCSEL_ERET: next_pc = {1'b0, epc_low};
      // jr may drop out of kernel mode but can never enter it.
      PCSEL_JR:   next_pc = {jr_target[31] & pc[31], jr_target[30:0]};
      PCSEL_BR:   next_pc = branch_target;
      PCSEL_J:    next_pc = {pc[31], jump_target_low};
      default:    next_pc = pc_plus4(pc);
    endcase
  end

  assign flush = (sel != PCSEL_SEQ) && (sel != PCSEL_HOLD);

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS IF stage: PC/EPC/irq-pending registers around the npc_select mux.
// Build macro FETCH_PERF_CNT_EN adds saturating fetch/stall/redirect counters.
module pc_fetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        eret,
  input  logic        exc_req,
  input  logic        irq_req,
  input  logic [31:0] epc_src,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_pcadd4,
  output logic [31:0] if_inst,
  output logic        flush_fd,
  output logic [31:0] epc,
  output logic        kernel
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] redirect_cnt
`endif
);

  logic [31:0] pc_q, pc_d, next_pc;
  logic [31:0] epc_q, epc_d;
  logic        irq_pending_q, irq_pending_d;
  logic        irq_accept, mux_flush;
  pcsel_e      sel;

  assign irq_accept = (irq_req | irq_pending_q) & ~pc_q[31] & ~exc_req;

  npc_select #(
    .IRQ_VEC(IRQ_VEC),
    .EXC_VEC(EXC_VEC)
  ) u_npc_select (
    .pc              (pc_q),
    .epc_low         (epc_q[30:0]),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump            (jump),
    .jump_target_low (jump_target[30:0]),
    .jr              (jr),
    .jr_target       (jr_target),
    .eret            (eret),
    .exc_req         (exc_req),
    .irq_accept      (irq_accept),
    .next_pc         (next_pc),
    .sel             (sel),
    .flush           (mux_flush)
  );

  always_comb begin
    pc_d          = next_pc;
    epc_d         = epc_q;
    if (sel == PCSEL_EXC || sel == PCSEL_IRQ) epc_d = epc_src;
    // An irq blocked by kernel mode or a same-cycle exception is remembered.
    irq_pending_d = ~irq_accept & (irq_pending_q | irq_req);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      epc_q         <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign kernel    = pc_q[31];
  assign if_pcadd4 = pc_plus4(pc_q);
  assign if_inst   = inst_rdata;
  assign flush_fd  = mux_flush & ~reset;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (sel == PCSEL_HOLD) stall_cnt_d = sat_inc(stall_cnt_q);
    else                   fetch_cnt_d = sat_inc(fetch_cnt_q);
    if (flush_fd)          redirect_cnt_d = sat_inc(redirect_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q    <= '0;
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected PC/EPC pushed per step, popped after the edge.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jr, eret, exc_req, irq_req;
  logic [31:0] branch_target, jump_target, jr_target, epc_src, inst_rdata;
  logic [31:0] pc, if_pcadd4, if_inst, epc;
  logic        flush_fd, kernel;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, redirect_cnt;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc, m_epc;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .eret          (eret),
    .exc_req       (exc_req),
    .irq_req       (irq_req),
    .epc_src       (epc_src),
    .inst_rdata    (inst_rdata),
    .pc            (pc),
    .if_pcadd4     (if_pcadd4),
    .if_inst       (if_inst),
    .flush_fd      (flush_fd),
    .epc           (epc),
    .kernel        (kernel)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt),
    .redirect_cnt  (redirect_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge with inputs already set; checks combinational
  // outputs at the negedge, then the registered state after the next edge.
  task automatic step(input logic [31:0] exp_pc, input logic exp_flush);
    exp_t e;
    inst_rdata = $urandom;
    e.pc  = exp_pc;
    e.epc = m_epc;
    sb.push_back(e);
    #4;
    check("flush_fd", {31'd0, flush_fd}, {31'd0, exp_flush});
    check("if_inst", if_inst, inst_rdata);
    check("if_pcadd4", if_pcadd4, {m_pc[31], m_pc[30:0] + 31'd4});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("pc", pc, e.pc);
      check("epc", epc, e.epc);
      check("kernel", {31'd0, kernel}, {31'd0, e.pc[31]});
      m_pc = e.pc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    eret = 1'b0; exc_req = 1'b0; irq_req = 1'b0;
    branch_target = '0; jump_target = '0; jr_target = '0; epc_src = '0;
    inst_rdata = 32'h2408_0001;
    m_pc = 32'h0040_0000; m_epc = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_pc", pc, 32'h0040_0000);
    check("reset_epc", epc, 32'h0);
    check("reset_kernel", {31'd0, kernel}, 32'd0);

    // Free-running fetch up to 0x00400010.
    step(32'h0040_0004, 1'b0);
    step(32'h0040_0008, 1'b0);
    step(32'h0040_000C, 1'b0);
    step(32'h0040_0010, 1'b0);

    // Stall holds; a branch under stall is ignored.
    stall = 1'b1;
    step(32'h0040_0010, 1'b0);
    step(32'h0040_0010, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h0040_0100;
    step(32'h0040_0010, 1'b0);
    stall = 1'b0; branch_taken = 1'b0;
    step(32'h0040_0014, 1'b0);
    step(32'h0040_0018, 1'b0);
    step(32'h0040_001C, 1'b0);
    step(32'h0040_0020, 1'b0);

    branch_taken = 1'b1; branch_target = 32'h0040_0100;
    step(32'h0040_0100, 1'b1);
    branch_taken = 1'b0;

    // Interrupt from user mode, then eret.
    irq_req = 1'b1; epc_src = 32'h0040_002C; m_epc = 32'h0040_002C;
    step(32'h8000_0004, 1'b1);
    irq_req = 1'b0;
    eret = 1'b1;
    step(32'h0040_002C, 1'b1);
    eret = 1'b0;

    // Exception enters kernel; an irq pulse there is deferred until after eret.
    exc_req = 1'b1; epc_src = 32'h0040_0030; m_epc = 32'h0040_0030;
    step(32'h8000_0008, 1'b1);
    exc_req = 1'b0; irq_req = 1'b1;
    step(32'h8000_000C, 1'b0);
    irq_req = 1'b0;
    step(32'h8000_0010, 1'b0);
    eret = 1'b1;
    step(32'h0040_0030, 1'b1);
    eret = 1'b0; epc_src = 32'h0040_0034; m_epc = 32'h0040_0034;
    step(32'h8000_0004, 1'b1);
    eret = 1'b1;
    step(32'h0040_0034, 1'b1);
    eret = 1'b0;

    // Exception and irq together: exception wins, irq stays pending.
    exc_req = 1'b1; irq_req = 1'b1; epc_src = 32'h0040_0038; m_epc = 32'h0040_0038;
    step(32'h8000_0008, 1'b1);
    exc_req = 1'b0; irq_req = 1'b0;
    step(32'h8000_000C, 1'b0);
    eret = 1'b1;
    step(32'h0040_0038, 1'b1);
    eret = 1'b0; epc_src = 32'h0040_003C; m_epc = 32'h0040_003C;
    step(32'h8000_0004, 1'b1);
    eret = 1'b1;
    step(32'h0040_003C, 1'b1);
    eret = 1'b0;

    // jr from user mode cannot set pc[31].
    jr = 1'b1; jr_target = 32'h8000_1000;
    step(32'h0000_1000, 1'b1);
    jr = 1'b0;

    // j in kernel keeps pc[31]; jr in kernel may clear it.
    exc_req = 1'b1; epc_src = 32'h0000_1004; m_epc = 32'h0000_1004;
    step(32'h8000_0008, 1'b1);
    exc_req = 1'b0; jump = 1'b1; jump_target = 32'h0000_0040;
    step(32'h8000_0040, 1'b1);
    jump = 1'b0; jr = 1'b1; jr_target = 32'h0000_2000;
    step(32'h0000_2000, 1'b1);
    jr = 1'b0;

    // irq overrides stall.
    stall = 1'b1; irq_req = 1'b1; epc_src = 32'h0000_2004; m_epc = 32'h0000_2004;
    step(32'h8000_0004, 1'b1);
    stall = 1'b0; irq_req = 1'b0;

    // PC+4 wraps in 31 bits and keeps the kernel bit.
    jr = 1'b1; jr_target = 32'hFFFF_FFFC;
    step(32'hFFFF_FFFC, 1'b1);
    jr = 1'b0;
    step(32'h8000_0000, 1'b0);

    // Reset during a redirect wins: no EPC capture, pending irq cleared.
    reset = 1'b1; exc_req = 1'b1; irq_req = 1'b1; epc_src = 32'h1234_5678; m_epc = 32'h0;
    step(32'h0040_0000, 1'b0);
    reset = 1'b0; exc_req = 1'b0; irq_req = 1'b0;
    step(32'h0040_0004, 1'b0);
    step(32'h0040_0008, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline. Directly upstream of the IF/ID pipeline register.
- Owns the PC register and drives the instruction-memory address.
- Arbitrates all next-PC sources: sequential, branch, jump, jr, exception, interrupt, eret. Maintains the supervisor bit (PC[31]) and EPC.
- Produces IF_PCadd4 and IF_Inst plus the IF/ID flush request.

Parameters:
- RESET_PC, 32'h00400000, PC value after reset.
- IRQ_VEC, 32'h80000004, interrupt vector.
- EXC_VEC, 32'h80000008, exception (illegal-op) vector.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  load-use/hazard hold from hazard unit.
- branch_taken  in  1  branch resolved taken in ID.
- branch_target  in  32  branch destination.
- jump  in  1  j/jal in ID.
- jump_target  in  32  j/jal destination.
- jr  in  1  jr/jalr in ID.
- jr_target  in  32  forwarded rs value.
- eret  in  1  return-from-exception in ID.
- exc_req  in  1  undefined-instruction exception from ID.
- irq_req  in  1  external interrupt (timer), level.
- epc_src  in  32  PC+4 of instruction to resume (ID_PCadd4).
- inst_rdata  in  32  combinational instruction-memory read data.
- pc  out  32  current PC, to instruction memory.
- if_pcadd4  out  32  PC+4, to IF/ID.
- if_inst  out  32  instruction, to IF/ID.
- flush_fd  out  1  bubble IF/ID this cycle.
- epc  out  32  saved return address.
- kernel  out  1  equals pc[31].

Behaviour:
- Reset (sync, active-high): pc=RESET_PC, epc=0, irq_pending=0. Combinational outputs follow: kernel=0, if_pcadd4=RESET_PC+4, flush_fd=0.
- if_inst = inst_rdata (0 latency). if_pcadd4 = {pc[31], pc[30:0]+4}; the add wraps in 31 bits and pc[31] is preserved.
- Next-PC priority, highest first:
  1. reset.
  2. exc_req → EXC_VEC.
  3. irq accepted → IRQ_VEC.
  4. eret → epc with bit31 cleared.
  5. jr → jr_target. pc[31] may only be cleared by jr, never set: if kernel=0, target bit31 is forced to 0.
  6. branch_taken → branch_target.
  7. jump → {pc[31], jump_target[30:0]}.
  8. stall → pc held.
  9. otherwise if_pcadd4.
- stall suppresses items 4–7: the redirect is re-presented by ID next cycle. Items 2–3 override stall.
- irq accepted only when kernel=0 and no exc_req in the same cycle. irq_req seen while kernel=1 sets irq_pending; it is taken on the first cycle kernel=0. irq_pending clears on accept.
- On exception/irq accept: epc <= epc_src. For irq the resumed instruction is the one in ID, so epc_src is its PC.
- flush_fd=1 in any cycle where items 2–7 are taken. Otherwise 0, including during stall.
- Simultaneous exc_req and irq: exception wins, irq stays pending. Reset mid-redirect: reset wins, no epc update.

Optional Feature:
- FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt, stall_cnt, redirect_cnt (32 bits each, reset 0, saturating at all-ones).
  - fetch_cnt increments on each sequential or redirect PC update.
  - stall_cnt increments on each held cycle.
  - redirect_cnt increments when flush_fd=1.
- Undefined: ports and counters absent, no other behavioural change.

Decomposition:
- Shared package/header mips_defs: RESET_PC, IRQ_VEC, EXC_VEC defaults and the next-PC select encoding (PCSEL_SEQ, PCSEL_BR, PCSEL_J, PCSEL_JR, PCSEL_ERET, PCSEL_IRQ, PCSEL_EXC, PCSEL_HOLD).
- One sub-module, npc_select: purely combinational priority mux producing next_pc, sel and flush. pc_fetch_unit keeps the registers (pc, epc, irq_pending, optional counters).

Test Plan:
- Reset, then 3 free-running cycles → pc = 0x00400000, 0x00400004, 0x00400008; flush_fd=0.
- stall=1 for 2 cycles at pc=0x00400010 → pc holds 0x00400010; release → 0x00400014. branch_taken with stall=1 → ignored.
- branch_taken=1, target 0x00400100, at pc=0x00400020 → next pc=0x00400100, flush_fd=1 that cycle.
- irq_req with kernel=0, epc_src=0x0040002C → pc=0x80000004, epc=0x0040002C, kernel=1. Then eret → pc=0x0040002C, kernel=0.
- irq_req pulsed while kernel=1 → no redirect; taken on the first cycle after eret → pc=0x80000004. exc_req and irq_req together → pc=0x80000008, irq taken later.
- jr target 0x80001000 from kernel=0 → pc=0x00001000; j target 0x00000040 at kernel=1 → pc=0x80000040.
